// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - gate op codes, sequencer states and the expected-output function
package gate_seq_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_STEP = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  function automatic logic expected_out(input logic [1:0] op, input logic a, input logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// rtl/gate_truth_table_sequencer.sv - walks a 2-input gate through its truth table and flags mismatches
module gate_truth_table_sequencer
  import gate_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 24_000_000,
  parameter int GATE_OP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  input  logic       dut_out0,
  output logic       dut_in0,
  output logic       dut_in1,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          start_q;
  logic          gate_q;
  logic          mismatch;
  logic [3:0]    fail_next;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out0),
    .q     (gate_q)
  );

  assign mismatch  = gate_q != expected_out(2'(GATE_OP), vec_idx[0], vec_idx[1]);
  assign fail_next = fail_vec | ({3'b000, mismatch} << vec_idx);

  // The gate inputs are only exercised while a run is active; idle and done park them low.
  assign dut_in0 = busy & vec_idx[0];
  assign dut_in1 = busy & vec_idx[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      start_q  <= 1'b0;
      vec_idx  <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 4'd0;
    end else begin
      // A start seen mid-run is dropped here so it cannot leak into the following DONE state.
      start_q <= start & ((state == S_IDLE) | (state == S_DONE));
      case (state)
        S_IDLE, S_DONE: begin
          if (start_q) begin
            state    <= S_RUN;
            cnt      <= '0;
            vec_idx  <= 2'd0;
            fail_vec <= 4'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt == CNT_LAST) begin
            fail_vec <= fail_next;
            if (vec_idx == 2'd3) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_next == 4'd0);
            end else if (step_mode) begin
              state <= S_WAIT_STEP;
            end else begin
              vec_idx <= vec_idx + 2'd1;
              cnt     <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_STEP: begin
          if (step) begin
            state   <= S_RUN;
            vec_idx <= vec_idx + 2'd1;
            cnt     <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// tb/tb_gate_truth_table_sequencer.sv - randomized self-checking bench for gate_truth_table_sequencer
module tb_gate_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, step_mode, step;
  logic       dut_out0, dut_in0, dut_in1, busy, done, pass;
  logic [1:0] vec_idx;
  logic [3:0] fail_vec;
  logic [3:0] tt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // Gate under test modelled as a truth table indexed by {in1, in0}.
  assign dut_out0 = tt[{dut_in1, dut_in0}];

  gate_truth_table_sequencer #(.STEP_CYCLES(4), .GATE_OP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .dut_out0  (dut_out0),
    .dut_in0   (dut_in0),
    .dut_in1   (dut_in1),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec)
  );

  // Expected fail mask for an OR check: vector i should read 1 exactly when i is nonzero.
  function automatic logic [3:0] exp_fail(input logic [3:0] t);
    logic [3:0] f;
    f = 4'd0;
    for (int i = 0; i < 4; i++) f[i] = (t[i] != (i != 0));
    return f;
  endfunction

  function automatic logic [3:0] done_mask(input int n);
    return 4'((1 << n) - 1);
  endfunction

  function automatic logic [10:0] obs();
    return {busy, done, pass, vec_idx, dut_in1, dut_in0, fail_vec};
  endfunction

  function automatic logic [10:0] mk(input logic b, input logic d, input logic p,
                                     input logic [1:0] idx, input logic [1:0] din,
                                     input logic [3:0] f);
    return {b, d, p, idx, din, f};
  endfunction

  task automatic test_reset();
    logic [10:0] e;
    rst_n = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0; tt = 4'b1110;
    #3 rst_n = 1'b0;
    #1;
    e = 11'd0;
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL reset: got %b want %b", obs(), e); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_ignores_step();
    logic [10:0] e;
    e = 11'd0;
    step = 1'b1; @(negedge clk); step = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL idle_step c=%0d: got %b want %b", c, obs(), e); end
      @(negedge clk);
    end
  endtask

  // Free-running run; inj >= 0 pulses start at that cycle of the run.
  task automatic run_auto(input logic [3:0] t, input int inj, input string name);
    logic [3:0]  ef;
    logic [10:0] e;
    int          v;
    tt = t; step_mode = 1'b0; ef = exp_fail(t);
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      v = c / 4;
      e = mk(1'b1, 1'b0, 1'b0, 2'(v), 2'(v), ef & done_mask(v));
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL %s run c=%0d: got %b want %b", name, c, obs(), e); end
      start = (c == inj);
      @(negedge clk);
    end
    start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      e = mk(1'b0, 1'b1, ef == 4'd0, 2'd3, 2'd0, ef);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL %s done h=%0d: got %b want %b", name, h, obs(), e); end
      @(negedge clk);
    end
  endtask

  task automatic test_correct_or();   run_auto(4'b1110, -1, "correct_or"); endtask
  task automatic test_tied_low();     run_auto(4'b0000, -1, "tied_low");   endtask
  task automatic test_and_gate();     run_auto(4'b1000, -1, "and_gate");   endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) run_auto(4'($urandom_range(0, 15)), -1, "random");
  endtask

  task automatic test_back_to_back();
    run_auto(4'b0101, 8, "start_mid_run");
    run_auto(4'b1110, -1, "start_in_done");
  endtask

  task automatic test_step_mode();
    logic [3:0]  ef;
    logic [10:0] e;
    int          gap;
    for (int r = 0; r < 3; r++) begin
      tt = (r == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      ef = exp_fail(tt);
      step_mode = 1'b1;
      start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
      for (int v = 0; v < 4; v++) begin
        for (int c = 0; c < 4; c++) begin
          e = mk(1'b1, 1'b0, 1'b0, 2'(v), 2'(v), ef & done_mask(v));
          vecs++;
          if (obs() !== e) begin errs++; $display("FAIL step_run v=%0d c=%0d: got %b want %b", v, c, obs(), e); end
          @(negedge clk);
        end
        if (v < 3) begin
          gap = (v == 0 && r == 0) ? 50 : $urandom_range(1, 12);
          for (int g = 0; g < gap; g++) begin
            e = mk(1'b1, 1'b0, 1'b0, 2'(v), 2'(v), ef & done_mask(v + 1));
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL step_wait v=%0d g=%0d: got %b want %b", v, g, obs(), e); end
            @(negedge clk);
          end
          step = 1'b1; @(negedge clk); step = 1'b0;
        end
      end
      e = mk(1'b0, 1'b1, ef == 4'd0, 2'd3, 2'd0, ef);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL step_done: got %b want %b", obs(), e); end
      step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL step_in_done: got %b want %b", obs(), e); end
    end
    step_mode = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [10:0] e;
    tt = 4'b1000; step_mode = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    repeat (8) @(negedge clk);
    e = mk(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 4'b0010);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL pre_reset: got %b want %b", obs(), e); end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (obs() !== 11'd0) begin errs++; $display("FAIL reset_mid: got %b want %b", obs(), 11'd0); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step = (c == 5);
      vecs++;
      if (obs() !== 11'd0) begin errs++; $display("FAIL post_reset c=%0d: got %b want %b", c, obs(), 11'd0); end
      @(negedge clk);
    end
    step = 1'b0;
    run_auto(4'b1110, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_idle_ignores_step();
    test_correct_or();
    test_tied_low();
    test_and_gate();
    test_random();
    test_back_to_back();
    test_step_mode();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
